// File: rtl/traffic_monitor_if.sv
// ---------------------------------------------------------------------------
// traffic_monitor_if
// Bundles the lamp-sampling inputs and the status outputs of traffic_monitor.
//   master : the side that drives lamps/strobes and reads status (controller
//            top level or bench)
//   slave  : the monitor itself
// Signals:
//   en, red, orange, green, clr_err      master -> slave
//   phase[1:0], phase_valid, dwell,
//   cycles, err, err_code[1:0]           slave -> master
// ---------------------------------------------------------------------------
interface traffic_monitor_if #(
  parameter int DWELL_W = 8,
  parameter int CYCLE_W = 16
);
  logic               en;
  logic               red;
  logic               orange;
  logic               green;
  logic               clr_err;
  logic [1:0]         phase;
  logic               phase_valid;
  logic [DWELL_W-1:0] dwell;
  logic [CYCLE_W-1:0] cycles;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output en, red, orange, green, clr_err,
    input  phase, phase_valid, dwell, cycles, err, err_code
  );

  modport slave (
    input  en, red, orange, green, clr_err,
    output phase, phase_valid, dwell, cycles, err, err_code
  );
endinterface

// File: rtl/traffic_monitor.sv
// ---------------------------------------------------------------------------
// traffic_monitor
// Receive-side checker for a three-lamp traffic light. Decodes the lamp
// pattern into a phase, checks transitions against the legal sequence
// RED -> RED_ORANGE -> GREEN -> ORANGE -> RED, measures per-phase dwell,
// counts completed cycles and latches the first error seen.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : traffic_monitor_if.slave
//            inputs  en (sample strobe), red, orange, green, clr_err
//            outputs phase, phase_valid, dwell, cycles, err, err_code
// All outputs are registered; a sample taken with en=1 is reflected on the
// same clock edge. clr_err overrides any sample in the same cycle.
// ---------------------------------------------------------------------------
module traffic_monitor #(
  parameter int DWELL_W   = 8,
  parameter int MIN_DWELL = 1,
  parameter int CYCLE_W   = 16
) (
  input logic             clk,
  input logic             reset,
  traffic_monitor_if.slave bus
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] PH_RED        = 2'd0;
  localparam logic [1:0] PH_RED_ORANGE = 2'd1;
  localparam logic [1:0] PH_GREEN      = 2'd2;
  localparam logic [1:0] PH_ORANGE     = 2'd3;

  localparam logic [1:0] EC_NONE    = 2'd0;
  localparam logic [1:0] EC_PATTERN = 2'd1;
  localparam logic [1:0] EC_TRANS   = 2'd2;
  localparam logic [1:0] EC_DWELL   = 2'd3;

  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CYCLE_W-1:0] cycles_q, cycles_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  // Lamp decode
  logic       legal;
  logic [1:0] dec;

  always_comb begin
    legal = 1'b1;
    dec   = PH_RED;
    case ({bus.red, bus.orange, bus.green})
      3'b100:  dec = PH_RED;
      3'b110:  dec = PH_RED_ORANGE;
      3'b001:  dec = PH_GREEN;
      3'b010:  dec = PH_ORANGE;
      default: legal = 1'b0;
    endcase
  end

  // A phase change that happens before the old phase reached MIN_DWELL ticks.
  // With MIN_DWELL=0 this can never be true.
  logic short_dwell;
  assign short_dwell = (MIN_DWELL > 0) && (int'(dwell_q) < MIN_DWELL);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    dwell_d       = dwell_q;
    cycles_d      = cycles_q;
    err_d         = err_q;
    err_code_d    = err_code_q;

    if (bus.clr_err) begin
      // Phase is left untouched; it is meaningless until re-acquired.
      state_d       = ST_SYNC;
      phase_valid_d = 1'b0;
      dwell_d       = '0;
      err_d         = 1'b0;
      err_code_d    = EC_NONE;
    end else if (bus.en) begin
      case (state_q)
        ST_SYNC: begin
          // Illegal patterns are expected at power-up; wait silently.
          if (legal) begin
            state_d       = ST_TRACK;
            phase_d       = dec;
            phase_valid_d = 1'b1;
            dwell_d       = DWELL_ONE;
          end
        end
        ST_TRACK: begin
          if (!legal) begin
            state_d       = ST_FAULT;
            phase_valid_d = 1'b0;
            if (!err_q) begin
              err_d      = 1'b1;
              err_code_d = EC_PATTERN;
            end
          end else if (dec == phase_q) begin
            if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DWELL_ONE;
          end else if (dec == phase_q + 2'd1) begin
            // Legal successor; a short dwell is flagged but tracking goes on.
            phase_d = dec;
            dwell_d = DWELL_ONE;
            if (phase_q == PH_ORANGE) cycles_d = cycles_q + CYCLE_W'(1);
            if (short_dwell && !err_q) begin
              err_d      = 1'b1;
              err_code_d = EC_DWELL;
            end
          end else begin
            state_d       = ST_FAULT;
            phase_valid_d = 1'b0;
            if (!err_q) begin
              err_d      = 1'b1;
              err_code_d = EC_TRANS;
            end
          end
        end
        default: begin
          // FAULT: lamps ignored until clr_err.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SYNC;
      phase_q       <= PH_RED;
      phase_valid_q <= 1'b0;
      dwell_q       <= '0;
      cycles_q      <= '0;
      err_q         <= 1'b0;
      err_code_q    <= EC_NONE;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      dwell_q       <= dwell_d;
      cycles_q      <= cycles_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.dwell       = dwell_q;
  assign bus.cycles      = cycles_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_monitor
// Two monitor instances share one stimulus stream:
//   dut0 : DWELL_W=8, MIN_DWELL=1, CYCLE_W=16
//   dut1 : DWELL_W=4, MIN_DWELL=2, CYCLE_W=4 (short-dwell and cycle wrap
//          reachable in a short run)
// A behavioural model per instance is stepped on every sampled edge and
// compared against the outputs on each falling edge; directed literal
// checks pin the model's behaviour at known points.
// ---------------------------------------------------------------------------
module tb_traffic_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, red, orange, green, clr_err;

  traffic_monitor_if #(.DWELL_W(8), .CYCLE_W(16)) if0 ();
  traffic_monitor_if #(.DWELL_W(4), .CYCLE_W(4))  if1 ();

  assign if0.en = en;  assign if0.red = red;  assign if0.orange = orange;
  assign if0.green = green;  assign if0.clr_err = clr_err;
  assign if1.en = en;  assign if1.red = red;  assign if1.orange = orange;
  assign if1.green = green;  assign if1.clr_err = clr_err;

  traffic_monitor #(.DWELL_W(8), .MIN_DWELL(1), .CYCLE_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  traffic_monitor #(.DWELL_W(4), .MIN_DWELL(2), .CYCLE_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  localparam int DMAX [2] = '{255, 15};
  localparam int MIND [2] = '{1, 2};
  localparam int CMOD [2] = '{65536, 16};

  localparam logic [2:0] P_RED = 3'b100, P_RO = 3'b110, P_GRN = 3'b001, P_ORG = 3'b010;

  // Model: mode 0=waiting for a legal pattern, 1=tracking, 2=faulted
  int m_mode [2], m_phase [2], m_pv [2], m_dwell [2], m_cyc [2], m_err [2], m_code [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic minit();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_phase[i] = 0; m_pv[i] = 0; m_dwell[i] = 0;
      m_cyc[i] = 0; m_err[i] = 0; m_code[i] = 0;
    end
  endtask

  task automatic mraise(input int i, input int c);
    if (m_err[i] == 0) begin
      m_err[i]  = 1;
      m_code[i] = c;
    end
  endtask

  task automatic mstep(input int i, input logic e, input logic c, input logic [2:0] rog);
    int d;
    case (rog)
      P_RED:   d = 0;
      P_RO:    d = 1;
      P_GRN:   d = 2;
      P_ORG:   d = 3;
      default: d = -1;
    endcase
    if (c) begin
      m_mode[i] = 0; m_pv[i] = 0; m_dwell[i] = 0; m_err[i] = 0; m_code[i] = 0;
    end else if (e) begin
      if (m_mode[i] == 0) begin
        if (d >= 0) begin
          m_mode[i] = 1; m_phase[i] = d; m_pv[i] = 1; m_dwell[i] = 1;
        end
      end else if (m_mode[i] == 1) begin
        if (d < 0) begin
          mraise(i, 1); m_mode[i] = 2; m_pv[i] = 0;
        end else if (d == m_phase[i]) begin
          if (m_dwell[i] < DMAX[i]) m_dwell[i]++;
        end else if (d == (m_phase[i] + 1) % 4) begin
          if (m_dwell[i] < MIND[i]) mraise(i, 3);
          if (m_phase[i] == 3) m_cyc[i] = (m_cyc[i] + 1) % CMOD[i];
          m_phase[i] = d;
          m_dwell[i] = 1;
        end else begin
          mraise(i, 2); m_mode[i] = 2; m_pv[i] = 0;
        end
      end
    end
  endtask

  // Drive one cycle; the model sees exactly what the DUT samples at the edge.
  task automatic tick(input logic e, input logic [2:0] rog, input logic c);
    en = e; {red, orange, green} = rog; clr_err = c;
    @(posedge clk);
    if (reset) begin
      mstep(0, e, c, rog);
      mstep(1, e, c, rog);
    end
    #1;
    en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic sample(input logic [2:0] rog, input int n);
    for (int k = 0; k < n; k++) tick(1'b1, rog, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    minit();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic cmp_inst(input int i, input int ph, input int pv, input int dw,
                          input int cy, input int er, input int cd);
    string p;
    p = $sformatf("dut%0d", i);
    chk({p, " phase_valid"}, pv, m_pv[i]);
    chk({p, " dwell"},       dw, m_dwell[i]);
    chk({p, " cycles"},      cy, m_cyc[i]);
    chk({p, " err"},         er, m_err[i]);
    chk({p, " err_code"},    cd, m_code[i]);
    if (m_pv[i] == 1 || m_mode[i] == 2) chk({p, " phase"}, ph, m_phase[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, int'(if0.phase), int'(if0.phase_valid), int'(if0.dwell),
               int'(if0.cycles), int'(if0.err), int'(if0.err_code));
      cmp_inst(1, int'(if1.phase), int'(if1.phase_valid), int'(if1.dwell),
               int'(if1.cycles), int'(if1.err), int'(if1.err_code));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [2:0] pats [4];
  int cur;
  int r;

  initial begin
    pats[0] = P_RED; pats[1] = P_RO; pats[2] = P_GRN; pats[3] = P_ORG;
    reset = 1'b0; en = 1'b0; red = 1'b0; orange = 1'b0; green = 1'b0; clr_err = 1'b0;
    minit();
    repeat (3) @(posedge clk);
    #1;
    chk("reset phase", int'(if0.phase), 0);
    chk("reset phase_valid", int'(if0.phase_valid), 0);
    chk("reset dwell", int'(if0.dwell), 0);
    chk("reset cycles", int'(if0.cycles), 0);
    chk("reset err", int'(if0.err), 0);
    chk("reset err_code", int'(if0.err_code), 0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Full legal cycle
    sample(P_RED, 3);
    chk("seq red phase", int'(if0.phase), 0);
    chk("seq red dwell", int'(if0.dwell), 3);
    sample(P_RO, 2);
    chk("seq ro phase", int'(if0.phase), 1);
    chk("seq ro dwell", int'(if0.dwell), 2);
    sample(P_GRN, 3);
    chk("seq grn phase", int'(if0.phase), 2);
    chk("seq grn dwell", int'(if0.dwell), 3);
    sample(P_ORG, 2);
    chk("seq org phase", int'(if0.phase), 3);
    chk("seq org dwell", int'(if0.dwell), 2);
    sample(P_RED, 1);
    chk("seq end phase", int'(if0.phase), 0);
    chk("seq end dwell", int'(if0.dwell), 1);
    chk("seq end cycles", int'(if0.cycles), 1);
    chk("seq end err", int'(if0.err), 0);
    chk("seq dut1 err", int'(if1.err), 0);

    // Synchronisation through dark lamps
    tick(1'b0, 3'b000, 1'b1);
    sample(3'b000, 2);
    chk("sync dark pv", int'(if0.phase_valid), 0);
    chk("sync dark err", int'(if0.err), 0);
    sample(P_RED, 1);
    chk("sync acquire pv", int'(if0.phase_valid), 1);
    chk("sync acquire dwell", int'(if0.dwell), 1);

    // Skip GREEN -> RED
    sample(P_RO, 1);
    sample(P_GRN, 1);
    sample(P_RED, 1);
    chk("skip err", int'(if0.err), 1);
    chk("skip err_code", int'(if0.err_code), 2);
    chk("skip pv", int'(if0.phase_valid), 0);
    chk("skip phase held", int'(if0.phase), 2);
    sample(3'b101, 1);
    chk("fault sticky code", int'(if0.err_code), 2);
    tick(1'b0, 3'b000, 1'b1);
    chk("clr err", int'(if0.err), 0);
    chk("clr pv", int'(if0.phase_valid), 0);

    // Short dwell on dut1 (MIN_DWELL=2)
    sample(P_RED, 1);
    sample(P_RO, 1);
    chk("short err", int'(if1.err), 1);
    chk("short code", int'(if1.err_code), 3);
    chk("short phase", int'(if1.phase), 1);
    chk("short pv", int'(if1.phase_valid), 1);
    chk("short dut0 err", int'(if0.err), 0);

    // Illegal pattern, then clear colliding with a legal sample
    tick(1'b0, 3'b000, 1'b1);
    sample(P_RED, 1);
    sample(3'b111, 1);
    chk("pattern code", int'(if0.err_code), 1);
    chk("pattern pv", int'(if0.phase_valid), 0);
    tick(1'b1, P_RED, 1'b1);
    chk("clr prio pv", int'(if0.phase_valid), 0);
    chk("clr prio err", int'(if0.err), 0);
    chk("clr prio dwell", int'(if0.dwell), 0);
    sample(P_RED, 1);
    chk("reacq pv", int'(if0.phase_valid), 1);
    chk("reacq dwell", int'(if0.dwell), 1);

    // Dwell saturation: 300 ticks of RED in total
    sample(P_RED, 299);
    chk("sat dut0 dwell", int'(if0.dwell), 255);
    chk("sat dut1 dwell", int'(if1.dwell), 15);

    // en=0 holds state
    tick(1'b0, P_GRN, 1'b0);
    chk("hold dwell", int'(if0.dwell), 255);
    chk("hold pv", int'(if0.phase_valid), 1);

    // Cycle counting and wrap of the 4-bit counter
    pulse_reset();
    sample(P_RED, 2);
    for (int k = 0; k < 16; k++) begin
      sample(P_RO, 2); sample(P_GRN, 2); sample(P_ORG, 2); sample(P_RED, 2);
    end
    chk("cycles dut0", int'(if0.cycles), 16);
    chk("cycles dut1 wrap", int'(if1.cycles), 0);
    chk("cycles err", int'(if0.err), 0);

    // Asynchronous reset mid-phase
    sample(P_RO, 1);
    #2;
    reset = 1'b0;
    minit();
    #1;
    chk("async rst phase", int'(if0.phase), 0);
    chk("async rst pv", int'(if0.phase_valid), 0);
    chk("async rst dwell", int'(if0.dwell), 0);
    chk("async rst cycles", int'(if0.cycles), 0);
    chk("async rst err", int'(if0.err), 0);
    chk("async rst code", int'(if0.err_code), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Randomised traffic against the model
    cur = 0;
    for (int n = 0; n < 6000; n++) begin
      logic       e, c;
      logic [2:0] rog;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        pulse_reset();
      end else begin
        e = ($urandom_range(0, 99) < 85);
        c = ($urandom_range(0, 99) < 2);
        r = $urandom_range(0, 99);
        if (r < 55) rog = pats[cur];
        else if (r < 92) begin
          cur = (cur + 1) % 4;
          rog = pats[cur];
        end else rog = 3'($urandom_range(0, 7));
        tick(e, rog, c);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
Receive-side checker for the three-lamp traffic-light outputs (red, orange, green) produced by the light controller. It decodes the lamp pattern into a phase code and checks each transition against the legal sequence RED -> RED_ORANGE -> GREEN -> ORANGE -> RED. It also measures how long each phase lasts, counts completed cycles and latches the first error. It sits alongside the controller in the lab top level and drives status LEDs and the verification bench.

Parameters:
DWELL_W, 8, width of the per-phase dwell counter (in sample ticks).
MIN_DWELL, 1, minimum number of ticks a phase must last before a legal change is accepted without error.
CYCLE_W, 16, width of the completed-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  sample strobe; lamps are evaluated only on cycles where en=1.
red  in  1  red lamp.
orange  in  1  orange lamp.
green  in  1  green lamp.
clr_err  in  1  synchronous clear of the error state and return to SYNC.
phase  out  2  decoded phase: 0=RED, 1=RED_ORANGE, 2=GREEN, 3=ORANGE.
phase_valid  out  1  high while in TRACK.
dwell  out  DWELL_W  ticks spent in the current phase; saturates at the maximum value.
cycles  out  CYCLE_W  completed ORANGE->RED transitions; wraps modulo 2^CYCLE_W.
err  out  1  sticky error flag.
err_code  out  2  first error recorded: 0=none, 1=illegal pattern, 2=illegal transition, 3=short dwell.

Behaviour:
- Reset (reset=0, asynchronous): state=SYNC; phase=0, phase_valid=0, dwell=0, cycles=0, err=0, err_code=0.
- All outputs are registered. Response appears on the clock edge that samples en=1 (one-cycle latency). Cycles with en=0 hold all state.
- Decode (r,o,g): 100=RED, 110=RED_ORANGE, 001=GREEN, 010=ORANGE. All other patterns are illegal, including 000, 111, 011 and 101.
- Successor function: RED->RED_ORANGE->GREEN->ORANGE->RED.
- States:
  - SYNC:
    - Legal pattern -> TRACK; phase=decoded value, phase_valid=1, dwell=1.
    - Illegal pattern -> remain in SYNC, no error (covers power-up and lamps not yet driven).
  - TRACK:
    - Same phase -> dwell+1, saturating at 2^DWELL_W-1.
    - Successor phase -> phase updates, dwell=1. If old dwell<MIN_DWELL, the short-dwell error is raised and the block stays in TRACK. A transition from ORANGE to RED increments cycles.
    - Legal non-successor (including skips and reversals) -> illegal-transition error; go to FAULT.
    - Illegal pattern -> illegal-pattern error; go to FAULT.
  - FAULT:
    - phase_valid=0; phase and dwell hold their last TRACK values; cycles holds; lamps are ignored.
    - Leaves FAULT only on clr_err.
- Error latching: err is set on the first error. err_code records that first error only; later errors do not overwrite it until cleared.
- clr_err=1 (any state, regardless of en): state=SYNC, err=0, err_code=0, dwell=0, phase_valid=0; cycles is unchanged. clr_err has priority over any sample in the same cycle, and that sample is discarded.
- Reset asserted mid-operation clears everything immediately. After release, the block re-synchronises from SYNC.
- MIN_DWELL=0 disables the short-dwell check.

Test Plan:
- Reset, then en every cycle with 100 x3, 110 x2, 001 x3, 010 x2, 100 -> phase goes 0,1,2,3,0. dwell reaches 3,2,3,2 before each change. cycles=1, err=0.
- Start with 000, 000 then 100 -> phase_valid stays 0 for the first two samples, then 1. No error.
- In TRACK with GREEN, sample 100 -> err=1, err_code=2, phase_valid=0. A following 101 does not change err_code. clr_err -> err=0, state SYNC.
- MIN_DWELL=2: RED held 1 tick, then 110 -> err=1, err_code=3, phase=1, phase_valid remains 1.
- In TRACK, sample 111 -> err_code=1, FAULT. Assert clr_err in the same cycle as a legal sample -> sample ignored, SYNC entered. The next sample 100 re-acquires with dwell=1.
- Hold RED for 300 ticks with DWELL_W=8 -> dwell saturates at 255. Drive 65536 full cycles -> cycles wraps to 0. Assert reset mid-phase -> all outputs 0 asynchronously.
